// File: rtl/sample_pkg.sv
// Shared definitions for the sample link: transmitter FSM states, line levels
// and a counter-width helper used by the transmitter and its bit timer.
package sample_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic SAMPLE_IDLE  = 1'b1;
    localparam logic SAMPLE_START = 1'b0;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts clocks while enabled and pulses tick on the last
// clock of every BIT_CYCLES-long bit period.
module bit_timer
    import sample_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // With BIT_CYCLES=1 the count is pinned at 0 and tick is high every clock.
    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/sample_tx.sv
// Framed LSB-first serial transmitter for the sample line: idle high, one low
// start bit, DATA_W data bits, STOP_BITS high stop bits, each BIT_CYCLES long.
module sample_tx
    import sample_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sample,
    output logic              busy
);

    localparam int IW = cnt_width(DATA_W);
    localparam int SW = cnt_width(STOP_BITS);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_W - 1);
    localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     bit_idx;
    logic [SW-1:0]     stop_cnt;
    logic              tick;
    logic              timer_clear;

    // The timer is held at zero while idle so the start bit gets a full period
    // counted from the accepting edge.
    assign timer_clear = (state == IDLE);

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (timer_clear),
        .tick   (tick)
    );

    // The shift register always holds the not-yet-driven bits in its LSBs, so
    // the next line level is simply shreg[0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_cnt <= '0;
            sample   <= SAMPLE_IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg    <= tx_data;
                        state    <= START;
                        sample   <= SAMPLE_START;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        sample <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_BIT) begin
                            state   <= STOP;
                            sample  <= SAMPLE_IDLE;
                            bit_idx <= '0;
                        end else begin
                            sample  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state    <= IDLE;
                            stop_cnt <= '0;
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            stop_cnt <= stop_cnt + SW'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    sample   <= SAMPLE_IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_tx.sv
// Directed bench for sample_tx: default 8/4/1 instance plus a BIT_CYCLES=1,
// STOP_BITS=2 instance; outputs are sampled 1 time unit after each rising edge.
module tb_sample_tx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data, tx_data1;
    logic       tx_valid, tx_valid1;
    logic       tx_ready, sample, busy;
    logic       tx_ready1, sample1, busy1;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int FRAME = 40;   // (1 + 8 + 1) * 4

    always #5 clk = ~clk;

    sample_tx #(.DATA_W(8), .BIT_CYCLES(4), .STOP_BITS(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .sample  (sample),
        .busy    (busy)
    );

    sample_tx #(.DATA_W(8), .BIT_CYCLES(1), .STOP_BITS(2)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .tx_data (tx_data1),
        .tx_valid(tx_valid1),
        .tx_ready(tx_ready1),
        .sample  (sample1),
        .busy    (busy1)
    );

    // Expected line level k clocks after the accepting edge.
    function automatic logic frame_bit(input logic [7:0] d, input int k,
                                       input int bc, input int dw);
        int idx;
        idx = k / bc;
        if (idx == 0) return 1'b0;
        if (idx <= dw) return d[idx-1];
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    // Called just after the accepting edge; walks the whole frame and the
    // first idle clock. inject_k >= 0 pulses tx_valid with 0x3C mid-frame.
    task automatic check_frame(input logic [7:0] d, input string name, input int inject_k);
        logic [2:0] exp_v;
        for (int k = 0; k < FRAME; k++) begin
            exp_v = {frame_bit(d, k, 4, 8), 2'b01};
            n_cmp++;
            if ({sample, tx_ready, busy} !== exp_v) begin
                n_bad++;
                $display("FAIL %s k=%0d {sample,ready,busy}: got %b expected %b",
                         name, k, {sample, tx_ready, busy}, exp_v);
            end
            if (k == inject_k) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end else if (k == inject_k + 1) begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
            step();
        end
        n_cmp++;
        if ({sample, tx_ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL %s end-of-frame {sample,ready,busy}: got %b expected 110",
                     name, {sample, tx_ready, busy});
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tx_valid1 = 1'b0;
        tx_data1  = 8'h00;
        #12;
        n_cmp++;
        if ({sample, tx_ready, busy, sample1, tx_ready1, busy1} !== 6'b110110) begin
            n_bad++;
            $display("FAIL reset_state: got %b expected 110110",
                     {sample, tx_ready, busy, sample1, tx_ready1, busy1});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if ({sample, tx_ready, busy, sample1, tx_ready1, busy1} !== 6'b110110) begin
                n_bad++;
                $display("FAIL idle cycle %0d: got %b expected 110110",
                         i, {sample, tx_ready, busy, sample1, tx_ready1, busy1});
            end
        end
    endtask

    task automatic test_single();
        accept(8'hA5);
        check_frame(8'hA5, "frame_a5", -1);
    endtask

    task automatic test_back_to_back();
        int  low;
        bit  run;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        low = 0;
        run = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            if (run && sample === 1'b0) low++;
            else run = 1'b0;
            step();
        end
        n_cmp++;
        if (low != 36) begin
            n_bad++;
            $display("FAIL b2b_low_run: got %0d expected 36", low);
        end
        n_cmp++;
        if ({sample, tx_ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL b2b_idle_gap at E+40: got %b expected 110", {sample, tx_ready, busy});
        end
        step();
        tx_valid = 1'b0;
        check_frame(8'hFF, "b2b_second_ff", -1);
    endtask

    task automatic test_ignore_midframe();
        accept(8'hA5);
        check_frame(8'hA5, "ignore_3c", 10);
        step();
        n_cmp++;
        if ({sample, tx_ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL ignore_no_new_frame: got %b expected 110", {sample, tx_ready, busy});
        end
    endtask

    task automatic test_reset_midframe();
        accept(8'hA5);
        repeat (17) step();
        n_cmp++;
        if ({sample, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL pre_reset data bit3 {sample,busy}: got %b expected 01", {sample, busy});
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({sample, tx_ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL async_reset_midframe: got %b expected 110", {sample, tx_ready, busy});
        end
        step();
        reset_n = 1'b1;
        step();
        n_cmp++;
        if ({sample, tx_ready, busy} !== 3'b110) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %b expected 110", {sample, tx_ready, busy});
        end
        accept(8'h81);
        check_frame(8'h81, "after_reset_81", -1);
    endtask

    task automatic test_bit_cycles_one();
        logic [2:0] exp_v;
        tx_data1  = 8'h01;
        tx_valid1 = 1'b1;
        step();
        tx_valid1 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            exp_v = {frame_bit(8'h01, k, 1, 8), 2'b01};
            n_cmp++;
            if ({sample1, tx_ready1, busy1} !== exp_v) begin
                n_bad++;
                $display("FAIL bc1 k=%0d {sample,ready,busy}: got %b expected %b",
                         k, {sample1, tx_ready1, busy1}, exp_v);
            end
            step();
        end
        n_cmp++;
        if ({sample1, tx_ready1, busy1} !== 3'b110) begin
            n_bad++;
            $display("FAIL bc1 end-of-frame: got %b expected 110", {sample1, tx_ready1, busy1});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        step();
        test_back_to_back();
        step();
        test_ignore_midframe();
        step();
        test_reset_midframe();
        step();
        test_bit_cycles_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_tx.md
# sample_tx

Serial transmitter for the single-bit `sample` line. Accepts a parallel word over a valid/ready handshake and drives it onto `sample` as a framed, LSB-first bit stream: idle high, one low start bit, `DATA_W` data bits, `STOP_BITS` high stop bits. Each bit is held for `BIT_CYCLES` clocks. It is the source end of the sample link and produces exactly the zero-run patterns the detection logic downstream consumes.

## Interface
- `DATA_W`, 8, payload width in bits; must be at least 1.
- `BIT_CYCLES`, 4, clocks each bit is held on `sample`; must be at least 1.
- `STOP_BITS`, 1, number of high stop bits per frame; must be at least 1.

- `clk`  in  1  single clock; all logic is rising-edge triggered.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_W  word to transmit; sampled only on the accepting edge.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a word this cycle.
- `sample`  out  1  serial line, registered; idle level is 1.
- `busy`  out  1  a frame is in progress.

## Operation
- The FSM has four states: IDLE, START, DATA, STOP.
- **Reset** (`reset_n`=0, asynchronous): state goes to IDLE, `sample`=1, `tx_ready`=1, `busy`=0, and all counters and the shift register clear. A frame in progress is discarded immediately with no partial stop bit.
- **IDLE:**
  - `tx_ready`=1, `busy`=0, `sample`=1.
  - On an edge with `tx_valid`=1, the word is accepted: `tx_data` loads into the shift register, the state goes to START and `sample` becomes 0.
- **START:** holds `sample`=0 for `BIT_CYCLES` clocks, then goes to DATA with `sample` set to bit 0 of the word.
- **DATA:**
  - Each bit is held for `BIT_CYCLES` clocks, then the register shifts right and the bit index increments.
  - After bit `DATA_W-1` completes, the state goes to STOP and `sample` becomes 1.
- **STOP:** holds `sample`=1 for `STOP_BITS*BIT_CYCLES` clocks, then returns to IDLE.
- Outside IDLE: `tx_ready`=0 and `busy`=1. `tx_valid` is ignored and `tx_data` changes have no effect.
- **Counters** (all wrap to 0 at their terminal count):
  - Bit-cycle counter: width $clog2(BIT_CYCLES), minimum 1.
  - Bit index: width $clog2(DATA_W), minimum 1.
  - Stop counter: width $clog2(STOP_BITS), minimum 1.
- **BIT_CYCLES=1:** every bit lasts exactly one clock. No zero-length states are allowed.
- **Back-to-back words:** if `tx_valid` stays high, the next word is accepted on the first IDLE edge. Between frames there is at least one idle-high clock in addition to the stop bits.

## Timing
- Acceptance edge E: `sample` is 0 from E to E+`BIT_CYCLES`.
- Data bit i is driven from E+(1+i)·`BIT_CYCLES` to E+(2+i)·`BIT_CYCLES`.
- Stop bits are driven until E+F, where F=(1+`DATA_W`+`STOP_BITS`)·`BIT_CYCLES`.
- `tx_ready` rises at E+F, so the earliest next acceptance edge is E+F+1.
- `sample`, `tx_ready` and `busy` are registered outputs. There are no combinational paths from inputs to outputs.
- Latency from the accepting edge to the start-bit falling edge on `sample` is 0 clocks: `sample` is registered low on the accepting edge itself.

## Structure
- Shared package `sample_pkg`:
  - state enum `tx_state_t` (IDLE, START, DATA, STOP);
  - constant `SAMPLE_IDLE`=1'b1;
  - constant `SAMPLE_START`=1'b0.
- Sub-module `bit_timer`:
  - parameterised by `BIT_CYCLES`;
  - inputs `clk`, `reset_n`, `clear`;
  - output `tick`, a one-clock pulse on the last cycle of each bit period.
  - The FSM advances only on `tick`.
- Top level: FSM, shift register, bit index and stop counter.

## Test plan
- Reset, then idle 20 clocks: `sample`=1, `tx_ready`=1 and `busy`=0 throughout.
- `DATA_W`=8, `BIT_CYCLES`=4, send 0xA5:
  - `sample` holds 0 for 4 clocks;
  - then carries 1,0,1,0,0,1,0,1, each held 4 clocks;
  - then 1 for 4 clocks;
  - `tx_ready` returns high exactly 40 clocks after acceptance.
- `tx_valid` held high with 0x00 then 0xFF:
  - first frame shows a 36-clock low run (start plus 8 zero data bits);
  - second frame starts no earlier than 41 clocks after the first acceptance.
- Pulse `tx_valid` with 0x3C mid-frame while `busy`=1: it is ignored, and the current frame completes unchanged.
- Assert `reset_n`=0 during data bit 3:
  - `sample`=1 and `tx_ready`=1 immediately, without waiting for a clock edge;
  - after release, a new word 0x81 transmits correctly.
- `BIT_CYCLES`=1, `STOP_BITS`=2, send 0x01: observe the 11-clock frame 0,1,0,0,0,0,0,0,0,1,1.
